// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU operations,
// immediate formats and the opcodes the decoder recognises.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011
  } imm_src_e;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate format depends on the opcode alone, never on the FSM state.
  function automatic imm_src_e imm_src_for(input logic [6:0] opcode);
    case (opcode)
      OP_SW:     return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

  function automatic logic is_wait_state(input state_e s);
    return s inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, strobes and
// mux selects out. The controller side is the master.
interface multicycle_controller_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  logic [3:0] state;
  logic       trap;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state, trap
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state, trap
  );

endinterface

// File: rtl/alu_decoder.sv
// funct3/funct7 to ALU operation decode for R- and I-type instructions, plus
// a flag for R-type funct combinations the datapath does not implement.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic       is_rtype_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_ctrl_e  alu_control_o,
  output logic       illegal_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (funct3_i)
      3'b000:  alu_control_o = (is_rtype_i && funct7_i[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control_o = ALU_SLL;
      3'b010:  alu_control_o = ALU_SLT;
      3'b011:  alu_control_o = ALU_SLTU;
      3'b100:  alu_control_o = ALU_XOR;
      3'b101:  alu_control_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_control_o = ALU_OR;
      default: alu_control_o = ALU_AND;
    endcase
    // Only funct7 = 0 or the SUB/SRA alternate form are legal for R-type.
    if (is_rtype_i) begin
      illegal_o = !((funct7_i == 7'b0000000) ||
                    ((funct7_i == 7'b0100000) &&
                     ((funct3_i == 3'b000) || (funct3_i == 3'b101))));
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with bounded memory waits and a sticky
// trap state that only reset can leave.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       trap_q, trap_d;
  logic       wait_expired;

  alu_ctrl_e  funct_alu;
  logic       funct_illegal;

  logic       pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  alu_ctrl_e  alu_control;

  alu_decoder u_alu_decoder (
    .is_rtype_i   (bus.opcode == OP_R),
    .funct3_i     (bus.funct3),
    .funct7_i     (bus.funct7),
    .alu_control_o(funct_alu),
    .illegal_o    (funct_illegal)
  );

  // Trap when this cycle's miss would bring the counter up to the limit.
  assign wait_expired = (int'(wait_q) + 1) >= MEM_WAIT_MAX;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.mem_ready)      state_d = S_DECODE;
        else if (wait_expired)  state_d = S_TRAP;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = funct_illegal ? S_TRAP : S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BRANCH:    state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (bus.mem_ready)      state_d = S_MEMWB;
        else if (wait_expired)  state_d = S_TRAP;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (bus.mem_ready)      state_d = S_FETCH;
        else if (wait_expired)  state_d = S_TRAP;
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    // Staying in a wait state means mem_ready was low; any move clears the count.
    wait_d = (is_wait_state(state_q) && (state_d == state_q)) ? wait_q + 4'd1 : 4'd0;
    trap_d = trap_q | (state_d == S_TRAP);
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = bus.mem_ready;
        ir_write   = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = funct_alu;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        case (bus.funct3)
          3'b000:  pc_write = bus.zero;
          3'b001:  pc_write = ~bus.zero;
          default: pc_write = 1'b0;
        endcase
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      adr_src   = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.IRWrite    = ir_write;
  assign bus.MemWrite   = mem_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src_for(bus.opcode);
  assign bus.state      = state_q;
  assign bus.trap       = trap_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each step queues the expected
// output vector, then pops it and compares against the sampled DUT outputs.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_WAIT_MAX(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [22:0] vec;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  logic [2:0] exp_imm;

  // Expected outputs per state, straight from the controller's output table.
  function automatic logic [22:0] spec_out(input state_e st, input logic rdy,
                                           input logic br, input logic [3:0] alu,
                                           input logic [2:0] imm, input logic rst);
    logic       pcw, adr, irw, mw, rw, trp;
    logic [1:0] res, sa, sb;
    logic [3:0] ac;
    pcw = 1'b0; adr = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; ac = ALU_ADD;
    trp = (st == S_TRAP);
    case (st)
      S_FETCH:    begin sb = 2'b10; res = 2'b10; pcw = rdy; irw = rdy; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMREAD:  adr = 1'b1;
      S_MEMWB:    begin res = 2'b01; rw = 1'b1; end
      S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      S_EXECR:    begin sa = 2'b10; ac = alu; end
      S_EXECI:    begin sa = 2'b10; sb = 2'b01; ac = alu; end
      S_ALUWB:    rw = 1'b1;
      S_BRANCH:   begin sa = 2'b10; ac = ALU_SUB; pcw = br; end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      default:    ;
    endcase
    if (rst) {pcw, adr, irw, mw, rw} = 5'b0;
    return {st, trp, pcw, adr, irw, mw, rw, res, sa, sb, ac, imm};
  endfunction

  function automatic logic [22:0] obs();
    return {bus.state, bus.trap, bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite,
            bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
            bus.ImmSrc};
  endfunction

  // Called at a falling edge with inputs already set; ends at the next falling edge.
  task automatic step(input string tag, input state_e st, input logic br,
                      input logic [3:0] alu);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.vec = spec_out(st, bus.mem_ready, br, alu, exp_imm, reset);
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    total++;
    assert (obs() === got.vec) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", got.tag, obs(), got.vec);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [2:0] imm);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    exp_imm    = imm;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    set_instr(OP_R, 3'b000, 7'b0000000, IMM_I);
    @(negedge clk);
    step("reset_cycle", S_FETCH, 1'b0, ALU_ADD);
    reset = 1'b0;

    // add: FETCH, DECODE, EXECR, ALUWB
    bus.mem_ready = 1'b1;
    step("add_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("add_decode", S_DECODE, 1'b0, ALU_ADD);
    step("add_execr",  S_EXECR,  1'b0, ALU_ADD);
    step("add_aluwb",  S_ALUWB,  1'b0, ALU_ADD);

    // sub and R-type xor
    set_instr(OP_R, 3'b000, 7'b0100000, IMM_I);
    step("sub_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("sub_decode", S_DECODE, 1'b0, ALU_ADD);
    step("sub_execr",  S_EXECR,  1'b0, ALU_SUB);
    step("sub_aluwb",  S_ALUWB,  1'b0, ALU_ADD);
    set_instr(OP_R, 3'b100, 7'b0000000, IMM_I);
    step("xor_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("xor_decode", S_DECODE, 1'b0, ALU_ADD);
    step("xor_execr",  S_EXECR,  1'b0, ALU_XOR);
    step("xor_aluwb",  S_ALUWB,  1'b0, ALU_ADD);

    // I-type: srai uses funct7[5]; addi ignores it
    set_instr(OP_I, 3'b101, 7'b0100000, IMM_I);
    step("srai_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("srai_decode", S_DECODE, 1'b0, ALU_ADD);
    step("srai_execi",  S_EXECI,  1'b0, ALU_SRA);
    step("srai_aluwb",  S_ALUWB,  1'b0, ALU_ADD);
    set_instr(OP_I, 3'b000, 7'b0100000, IMM_I);
    step("addi_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("addi_decode", S_DECODE, 1'b0, ALU_ADD);
    step("addi_execi",  S_EXECI,  1'b0, ALU_ADD);
    step("addi_aluwb",  S_ALUWB,  1'b0, ALU_ADD);

    // lw with three wait cycles in MEMREAD
    set_instr(OP_LW, 3'b010, 7'b0000000, IMM_I);
    step("lw_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("lw_decode", S_DECODE, 1'b0, ALU_ADD);
    step("lw_memadr", S_MEMADR, 1'b0, ALU_ADD);
    bus.mem_ready = 1'b0;
    step("lw_memread_w1", S_MEMREAD, 1'b0, ALU_ADD);
    step("lw_memread_w2", S_MEMREAD, 1'b0, ALU_ADD);
    step("lw_memread_w3", S_MEMREAD, 1'b0, ALU_ADD);
    bus.mem_ready = 1'b1;
    step("lw_memread_ok", S_MEMREAD, 1'b0, ALU_ADD);
    step("lw_memwb",      S_MEMWB,   1'b0, ALU_ADD);

    // branches with zero=1, then bne with zero=0
    bus.zero = 1'b1;
    set_instr(OP_BRANCH, 3'b000, 7'b0000000, IMM_B);
    step("beq_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("beq_decode", S_DECODE, 1'b0, ALU_ADD);
    step("beq_taken",  S_BRANCH, 1'b1, ALU_ADD);
    set_instr(OP_BRANCH, 3'b001, 7'b0000000, IMM_B);
    step("bne_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("bne_decode", S_DECODE, 1'b0, ALU_ADD);
    step("bne_zero1",  S_BRANCH, 1'b0, ALU_ADD);
    bus.zero = 1'b0;
    step("bne2_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("bne2_decode", S_DECODE, 1'b0, ALU_ADD);
    step("bne_zero0",   S_BRANCH, 1'b1, ALU_ADD);

    // jal
    set_instr(OP_JAL, 3'b000, 7'b0000000, IMM_J);
    step("jal_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("jal_decode", S_DECODE, 1'b0, ALU_ADD);
    step("jal_jal",    S_JAL,    1'b0, ALU_ADD);
    step("jal_aluwb",  S_ALUWB,  1'b0, ALU_ADD);

    // sw interrupted by reset while MemWrite is held
    set_instr(OP_SW, 3'b010, 7'b0000000, IMM_S);
    step("sw_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("sw_decode", S_DECODE, 1'b0, ALU_ADD);
    step("sw_memadr", S_MEMADR, 1'b0, ALU_ADD);
    bus.mem_ready = 1'b0;
    step("sw_memwrite", S_MEMWRITE, 1'b0, ALU_ADD);
    reset = 1'b1;
    step("sw_reset_cycle", S_MEMWRITE, 1'b0, ALU_ADD);
    reset = 1'b0;
    step("sw_after_reset", S_FETCH, 1'b0, ALU_ADD);

    // undefined opcode traps after DECODE and stays trapped
    do_reset();
    bus.mem_ready = 1'b1;
    set_instr(7'b1111111, 3'b000, 7'b0000000, IMM_I);
    step("badop_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("badop_decode", S_DECODE, 1'b0, ALU_ADD);
    bus.zero = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("badop_trap%0d", i), S_TRAP, 1'b0, ALU_ADD);

    // unlisted R-type funct7 traps
    do_reset();
    set_instr(OP_R, 3'b000, 7'b0000001, IMM_I);
    step("badr_fetch",  S_FETCH,  1'b0, ALU_ADD);
    step("badr_decode", S_DECODE, 1'b0, ALU_ADD);
    step("badr_trap",   S_TRAP,   1'b0, ALU_ADD);

    // mem_ready stuck low in FETCH: 15 waiting cycles, then TRAP
    do_reset();
    bus.mem_ready = 1'b0;
    set_instr(OP_R, 3'b000, 7'b0000000, IMM_I);
    for (int i = 0; i < 15; i++) step($sformatf("fetch_wait%0d", i), S_FETCH, 1'b0, ALU_ADD);
    step("fetch_timeout",  S_TRAP, 1'b0, ALU_ADD);
    bus.mem_ready = 1'b1;
    step("fetch_trap_held", S_TRAP, 1'b0, ALU_ADD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
